// File: rtl/mmio_uart_ctrl_if.sv
// Core-side MMIO bus, retire strobe and UART handshakes for mmio_uart_ctrl.
// The slave modport is the controller; the master modport is the core/UART side.
interface mmio_uart_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        re;
    logic        inst_valid;
    logic [31:0] mmio_rdata;
    logic        mmio_hit;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    modport slave (
        input  addr, wdata, wbe, re, inst_valid,
        input  uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
        output mmio_rdata, mmio_hit,
        output uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
    );

    modport master (
        output addr, wdata, wbe, re, inst_valid,
        output uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
        input  mmio_rdata, mmio_hit,
        input  uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
    );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// MMIO controller: UART status/RX FIFO/TX holding register and cycle/instret
// counters, with 1-cycle registered load data matching dmem/BIOS latency.
module mmio_uart_ctrl #(
    parameter int unsigned RX_DEPTH      = 4,
    parameter logic [3:0]  MMIO_BASE_NIB = 4'h8
) (
    input  logic             clk,
    input  logic             rst,
    mmio_uart_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(RX_DEPTH);

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_RXDATA  = 8'h04;
    localparam logic [7:0] OFF_TXDATA  = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INSTRET = 8'h14;
    localparam logic [7:0] OFF_CNTRST  = 8'h18;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RX_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [7:0]       mem_q [RX_DEPTH];
    logic [7:0]       mem_d [RX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      instret_cnt_q, instret_cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             hit_q, hit_d;

    logic       sel, rd_en, wr_en, rx_ready, rx_nonempty, tx_ready, push, pop;
    logic [7:0] off;

    always_comb begin
        sel         = (bus.addr[31:28] == MMIO_BASE_NIB);
        off         = bus.addr[7:0];
        rd_en       = bus.re && sel;
        wr_en       = (bus.wbe != '0) && sel;
        rx_ready    = (count_q != DEPTH_C);
        rx_nonempty = (count_q != '0);
        tx_ready    = !tx_valid_q && bus.uart_tx_data_in_ready;
        push        = bus.uart_rx_data_out_valid && rx_ready;
        pop         = rd_en && (off == OFF_RXDATA) && rx_nonempty;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.uart_rx_data_out;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // TX holding register: a new byte is only accepted once the previous one left.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && bus.uart_tx_data_in_ready) begin
            tx_valid_d = 1'b0;
        end else if (!tx_valid_q && wr_en && (off == OFF_TXDATA) && bus.wbe[0]) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.wdata[7:0];
        end
    end

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        instret_cnt_d = instret_cnt_q + (bus.inst_valid ? 32'd1 : 32'd0);
        if (wr_en && (off == OFF_CNTRST)) begin
            cycle_cnt_d   = '0;
            instret_cnt_d = '0;
        end
    end

    // Read data reflects register state before this cycle's updates.
    always_comb begin
        hit_d   = rd_en;
        rdata_d = '0;
        if (rd_en) begin
            case (off)
                OFF_CTRL:    rdata_d = {30'd0, rx_nonempty, tx_ready};
                OFF_RXDATA:  rdata_d = rx_nonempty ? {24'd0, mem_q[rd_ptr_q]} : '0;
                OFF_CYCLE:   rdata_d = cycle_cnt_q;
                OFF_INSTRET: rdata_d = instret_cnt_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            rdata_q       <= '0;
            hit_q         <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
            rdata_q       <= rdata_d;
            hit_q         <= hit_d;
        end
    end

    assign bus.mmio_rdata             = rdata_q;
    assign bus.mmio_hit               = hit_q;
    assign bus.uart_rx_data_out_ready = rx_ready;
    assign bus.uart_tx_data_in        = tx_data_q;
    assign bus.uart_tx_data_in_valid  = tx_valid_q;
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: register reads, RX FIFO order/full/empty,
// TX hold and drop, counters with clear and wrap, and mid-operation reset.
module tb_mmio_uart_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mmio_uart_ctrl_if bus_if();

    mmio_uart_ctrl #(
        .RX_DEPTH      (4),
        .MMIO_BASE_NIB (4'h8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mmio_rd(input logic [31:0] a);
        bus_if.addr = a;
        bus_if.re   = 1'b1;
        tick();
        bus_if.re   = 1'b0;
        bus_if.addr = '0;
    endtask

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wbe   = be;
        tick();
        bus_if.wbe   = '0;
        bus_if.addr  = '0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        bus_if.uart_rx_data_out       = b;
        bus_if.uart_rx_data_out_valid = 1'b1;
        tick();
        bus_if.uart_rx_data_out_valid = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mmio_rd(a);
        check_eq({tag, "_hit"}, {31'd0, bus_if.mmio_hit}, 32'd1);
        check_eq(tag, bus_if.mmio_rdata, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.addr = '0;
        bus_if.wdata = '0;
        bus_if.wbe = '0;
        bus_if.re = 1'b0;
        bus_if.inst_valid = 1'b0;
        bus_if.uart_rx_data_out = '0;
        bus_if.uart_rx_data_out_valid = 1'b0;
        bus_if.uart_tx_data_in_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_hit", {31'd0, bus_if.mmio_hit}, 32'd0);
        check_eq("rst_rdata", bus_if.mmio_rdata, 32'd0);
        check_eq("rst_rx_ready", {31'd0, bus_if.uart_rx_data_out_ready}, 32'd1);
        check_eq("rst_tx_valid", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, bus_if.uart_tx_data_in}, 32'd0);
        rst = 1'b0;

        // Status read and non-MMIO read
        rd_expect("ctrl_idle", 32'h8000_0000, 32'h0000_0001);
        mmio_rd(32'h0000_0000);
        check_eq("nosel_hit", {31'd0, bus_if.mmio_hit}, 32'd0);
        check_eq("nosel_rdata", bus_if.mmio_rdata, 32'd0);
        tick();
        check_eq("idle_hit", {31'd0, bus_if.mmio_hit}, 32'd0);

        // Fill FIFO, attempt overflow, drain, read empty
        rx_push(8'h41);
        rx_push(8'h42);
        rx_push(8'h43);
        check_eq("ready_at3", {31'd0, bus_if.uart_rx_data_out_ready}, 32'd1);
        rx_push(8'h44);
        check_eq("ready_full", {31'd0, bus_if.uart_rx_data_out_ready}, 32'd0);
        rx_push(8'h99);
        rd_expect("ctrl_full", 32'h8000_0000, 32'h0000_0003);
        rd_expect("rx_pop0", 32'h8000_0004, 32'h41);
        check_eq("ready_after_pop", {31'd0, bus_if.uart_rx_data_out_ready}, 32'd1);
        rd_expect("rx_pop1", 32'h8000_0004, 32'h42);
        rd_expect("rx_pop2", 32'h8000_0004, 32'h43);
        rd_expect("rx_pop3", 32'h8000_0004, 32'h44);
        rd_expect("rx_empty", 32'h8000_0004, 32'h0);
        rd_expect("ctrl_empty", 32'h8000_0000, 32'h0000_0001);

        // Push and pop in the same cycle with 2 entries
        rx_push(8'h61);
        rx_push(8'h62);
        bus_if.uart_rx_data_out = 8'h55;
        bus_if.uart_rx_data_out_valid = 1'b1;
        rd_expect("pp_pop", 32'h8000_0004, 32'h61);
        bus_if.uart_rx_data_out_valid = 1'b0;
        rd_expect("pp_1", 32'h8000_0004, 32'h62);
        rd_expect("pp_2", 32'h8000_0004, 32'h55);
        rd_expect("pp_empty", 32'h8000_0004, 32'h0);

        // Full FIFO with a pop: the incoming byte must not be accepted
        rx_push(8'h71);
        rx_push(8'h72);
        rx_push(8'h73);
        rx_push(8'h74);
        bus_if.uart_rx_data_out = 8'h99;
        bus_if.uart_rx_data_out_valid = 1'b1;
        rd_expect("fp_pop", 32'h8000_0004, 32'h71);
        bus_if.uart_rx_data_out_valid = 1'b0;
        rd_expect("fp_1", 32'h8000_0004, 32'h72);
        rd_expect("fp_2", 32'h8000_0004, 32'h73);
        rd_expect("fp_3", 32'h8000_0004, 32'h74);
        rd_expect("fp_empty", 32'h8000_0004, 32'h0);

        // TX: ignored writes, then held byte with drop of a second write
        mmio_wr(32'h8000_0008, 32'h0000_0055, 4'b1110);
        check_eq("tx_wbe_ign", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd0);
        mmio_wr(32'h0000_0008, 32'h0000_0055, 4'b0001);
        check_eq("tx_nosel_ign", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd0);
        bus_if.uart_tx_data_in_ready = 1'b0;
        mmio_wr(32'h8000_0008, 32'h0000_01A3, 4'b0001);
        check_eq("tx_v1", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd1);
        check_eq("tx_d1", {24'd0, bus_if.uart_tx_data_in}, 32'hA3);
        mmio_wr(32'h8000_0008, 32'h0000_00BB, 4'b0001);
        check_eq("tx_v2", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd1);
        check_eq("tx_drop", {24'd0, bus_if.uart_tx_data_in}, 32'hA3);
        rd_expect("ctrl_txbusy", 32'h8000_0000, 32'h0000_0000);
        check_eq("tx_v4", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd1);
        bus_if.uart_tx_data_in_ready = 1'b1;
        tick();
        check_eq("tx_clear", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd0);
        check_eq("tx_hold_data", {24'd0, bus_if.uart_tx_data_in}, 32'hA3);
        rd_expect("ctrl_txidle", 32'h8000_0000, 32'h0000_0001);

        // Counters from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_if.inst_valid = (i < 6);
            tick();
        end
        bus_if.inst_valid = 1'b0;
        rd_expect("cycle10", 32'h8000_0010, 32'd10);
        rd_expect("instret6", 32'h8000_0014, 32'd6);
        bus_if.inst_valid = 1'b1;
        mmio_wr(32'h8000_0018, 32'hDEAD_BEEF, 4'b1111);
        bus_if.inst_valid = 1'b0;
        rd_expect("cycle_clr", 32'h8000_0010, 32'd0);
        rd_expect("instret_clr", 32'h8000_0014, 32'd0);
        rd_expect("off_unmapped", 32'h8000_0020, 32'd0);

        // Cycle counter wrap
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        rd_expect("cycle_max", 32'h8000_0010, 32'hFFFF_FFFF);
        rd_expect("cycle_wrap", 32'h8000_0010, 32'd0);

        // Reset mid-TX with a nonempty FIFO and a pending read
        bus_if.uart_tx_data_in_ready = 1'b0;
        mmio_wr(32'h8000_0008, 32'h0000_005A, 4'b0001);
        rx_push(8'h33);
        check_eq("pre_rst_valid", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd1);
        rst = 1'b1;
        mmio_rd(32'h8000_0004);
        rst = 1'b0;
        check_eq("mrst_valid", {31'd0, bus_if.uart_tx_data_in_valid}, 32'd0);
        check_eq("mrst_tx_data", {24'd0, bus_if.uart_tx_data_in}, 32'd0);
        check_eq("mrst_hit", {31'd0, bus_if.mmio_hit}, 32'd0);
        check_eq("mrst_rdata", bus_if.mmio_rdata, 32'd0);
        check_eq("mrst_rx_ready", {31'd0, bus_if.uart_rx_data_out_ready}, 32'd1);
        rd_expect("mrst_fifo_empty", 32'h8000_0004, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
Memory-mapped I/O controller sitting beside dmem in the memory/writeback path of the 3-stage core.
- Consumes the EX-stage address, store data and byte-enables.
- Returns registered load data to the WB mux with the same 1-cycle latency as dmem and BIOS.
- Owns the UART receiver/transmitter handshakes, a small RX FIFO, and the cycle and instret performance counters.

Parameters:
RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2)
MMIO_BASE_NIB, 4'h8, value of addr[31:28] that selects MMIO space

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
addr  input  32  EX-stage byte address (ALU result)
wdata  input  32  store data
wbe  input  4  store byte enables; any nonzero bit means write
re  input  1  EX-stage load strobe
inst_valid  input  1  one instruction retired this cycle (non-flushed, non-bubble)
mmio_rdata  output  32  registered load data for WB
mmio_hit  output  1  registered: the previous-cycle load targeted MMIO; WB selects mmio_rdata
uart_rx_data_out  input  8  receiver byte
uart_rx_data_out_valid  input  1  receiver byte valid
uart_rx_data_out_ready  output  1  controller can accept an RX byte
uart_tx_data_in  output  8  transmit byte
uart_tx_data_in_valid  output  1  transmit byte valid
uart_tx_data_in_ready  input  1  transmitter can accept a byte

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Selection: sel = (addr[31:28]==MMIO_BASE_NIB). Accesses with sel=0 are ignored entirely.
- Register map (offset = addr[7:0]; other offsets read 0 and ignore writes):
  - 0x00 UART control (RO): bit0 = tx_ready, bit1 = rx_nonempty.
  - 0x04 RX data (RO, pop on read).
  - 0x08 TX data (WO, byte lane 0).
  - 0x10 cycle_cnt (RO).
  - 0x14 instret_cnt (RO).
  - 0x18 counter reset (WO, any data).
- Read latency: exactly 1 cycle. If re&&sel at cycle N, then at N+1 mmio_hit=1 and mmio_rdata holds the value. Otherwise, at N+1 mmio_hit=0 and mmio_rdata=0.
- Read sampling: control and counter values are sampled at cycle N, i.e. before any update in cycle N.
- RX FIFO:
  - Circular buffer of RX_DEPTH x 8 with count register; pointers wrap modulo RX_DEPTH.
  - uart_rx_data_out_ready = (count != RX_DEPTH), combinational from registered count.
  - Push when uart_rx_data_out_valid && ready.
  - Pop when re&&sel at offset 0x04 and count != 0; mmio_rdata = {24'b0, head byte}.
  - Read of 0x04 when empty returns 0 and does not pop.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, ready=0, so no push occurs even if a pop happens the same cycle.
  - rx_nonempty = (count != 0).
- TX:
  - A write to 0x08 with wbe[0]=1 while tx_valid=0 loads wdata[7:0] into the holding register and sets tx_valid the next cycle.
  - tx_valid drives uart_tx_data_in_valid and stays high until a cycle with uart_tx_data_in_ready=1; it clears the following cycle.
  - A write while tx_valid=1 is dropped; software polls first.
  - Writes with wbe[0]=0 are ignored.
  - tx_ready = !tx_valid && uart_tx_data_in_ready.
- Counters:
  - cycle_cnt += 1 every cycle.
  - instret_cnt += 1 when inst_valid.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
  - A write to 0x18 sets both counters to 0 on the next edge, overriding the increment of that cycle.
- Simultaneous read and write in one cycle: not possible from the core; if it occurs, both take effect independently.
- Reset (applies mid-operation too, discarding pending TX and FIFO contents):
  - mmio_rdata=0, mmio_hit=0.
  - FIFO empty: count=0, pointers=0, uart_rx_data_out_ready=1.
  - tx_valid=0, uart_tx_data_in=0.
  - cycle_cnt=0, instret_cnt=0.

Test Plan:
1. Reset, then re at 0x80000000 with uart_tx_data_in_ready=1 and no RX -> next cycle mmio_hit=1, mmio_rdata=0x00000001.
2. Push 0x41, 0x42, 0x43, 0x44 via RX valid -> ready drops to 0 after the 4th. Reads of 0x80000004 return 0x41..0x44 in order. A 5th read returns 0, and ready returns to 1 after the first pop.
3. FIFO holding 2 entries, push 0x55 in the same cycle as a pop -> read returns the oldest byte, count stays 2, 0x55 emerges last.
4. sw 0x80000008 data 0x1A3 wbe=4'b0001 with tx_ready held 0 for 3 cycles -> uart_tx_data_in=0xA3, valid high 4 cycles. A second write during this window is dropped. Valid clears the cycle after ready=1.
5. 10 cycles after reset with inst_valid high on 6 of them -> reads of 0x80000010 and 0x80000014 return 10 and 6 (values at sample cycle). Write 0x80000018 -> the following read returns 0 or a small count from 0.
6. Force cycle_cnt=0xFFFFFFFF -> wraps to 0. Assert rst mid-TX with valid high -> next cycle valid=0, FIFO empty, mmio_rdata=0.
